microsequencer: RTL
===================

# microsequencer

Next-state generator for the microprogrammed control unit. Holds the current microstate and computes the 10-bit `next_state` address that the microstore decodes into the next control word. Selection is driven by the sequencing fields of that control word. It supports increment, jump, opcode dispatch, conditional branch, memory-wait with timeout, and subroutine call/return.

## Interface
- `FETCH_STATE`, default 10'd1: address taken on RETURN with an empty stack and on FETCH mode.
- `FAULT_STATE`, default 10'd43: address taken on memory-wait timeout.
- `WAIT_LIMIT`, default 8'd16: number of consecutive WAIT cycles with `moc` low before a timeout.
- `STACK_DEPTH`, default 4: number of return-address entries.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `ctrl_mode` input 3: sequencing mode from the control word.
- `cond_sel` input 2: condition source. 00 = `cond_true`, 01 = `moc`, 10 = `z_flag`, 11 = constant 1.
- `cond_inv` input 1: inverts the selected condition.
- `branch_target` input 10: target address from the control word.
- `dispatch_addr` input 10: opcode-derived entry address from the instruction decoder.
- `cond_true` input 1: result from the condition tester.
- `z_flag` input 1: ALU zero flag.
- `moc` input 1: memory operation complete.
- `hold` input 1: freezes the sequencer.
- `next_state` output 10: registered microstate address presented to the microstore.
- `stack_depth` output 3: number of valid return-stack entries.
- `stack_err` output 1: sticky flag for stack overflow or underflow.
- `mem_timeout` output 1: sticky flag for WAIT timeout.

## Operation
- Internal register `state_q` drives `next_state` directly. It is the current microstate, and `inc = state_q + 1` mod 1024 (1023 wraps to 0).
- Condition: `c = sel(cond_sel) ^ cond_inv`.
- Modes select the value loaded into `state_q` at the clock edge:
  - 000 INC: loads `inc`.
  - 001 JUMP: loads `branch_target`.
  - 010 DISPATCH: loads `dispatch_addr`.
  - 011 COND: loads `c ? branch_target : inc`.
  - 100 WAIT:
    - If `moc` = 1, loads `inc` and clears `wait_cnt`.
    - Otherwise, if `wait_cnt == WAIT_LIMIT-1`, loads `FAULT_STATE`, sets `mem_timeout`, and clears `wait_cnt`.
    - Otherwise, holds `state_q` and increments `wait_cnt`.
  - 101 CALL: pushes `inc` and loads `branch_target`. If the stack is full, there is no push, `stack_err` is set, and the jump still occurs.
  - 110 RETURN: pops the top entry into `state_q`. If the stack is empty, loads `FETCH_STATE` and sets `stack_err`.
  - 111 FETCH: loads `FETCH_STATE`, and the stack is emptied (depth to 0).
- `wait_cnt` (8-bit) is cleared on any cycle whose mode is not WAIT.
- Precedence: `reset` > `hold` > mode.
  - While `hold` = 1, all registers are held: state, stack, `wait_cnt`, and flags.
- Stack is LIFO: push writes `stack[depth]` and increments depth; pop reads `stack[depth-1]` and decrements depth.
- Sticky flags clear only on reset.

## Timing
- Exactly one microinstruction per cycle. The microstore output for `next_state` is combinational, and the mode/target fields are sampled at the next rising edge.
- Latency: mode decode to new `next_state` is 1 clock.
- Reset (async, `reset` = 0):
  - `next_state` = 0, `stack_depth` = 0, `wait_cnt` = 0, `stack_err` = 0, `mem_timeout` = 0.
  - Takes effect immediately, including mid-WAIT or mid-call.
  - After deassertion, the first edge evaluates the state-0 control word.
- WAIT timeout fires on the `WAIT_LIMIT`-th consecutive low-`moc` cycle. If `moc` = 1 on that same cycle, the advance to `inc` wins and there is no fault.
- A stack push or pop and the resulting state update occur on the same edge. A RETURN immediately following a CALL returns to the CALL address + 1.

## Configuration
- `MICROSEQ_STACK_EN` defined: CALL/RETURN behave as above with a `STACK_DEPTH`-entry stack.
- `MICROSEQ_STACK_EN` undefined:
  - No stack storage.
  - CALL behaves as JUMP.
  - RETURN behaves as FETCH.
  - `stack_depth` and `stack_err` are tied to 0.

## Test plan
- Reset and increment: hold `reset` = 0, then release with mode INC for 3 cycles -> `next_state` 0, 1, 2, 3. Forcing `state_q` = 1023 under INC -> 0.
- Conditional branch: mode COND, `cond_sel` = 10, `branch_target` = 20.
  - `z_flag` = 1, `cond_inv` = 0 -> 20.
  - `z_flag` = 1, `cond_inv` = 1 -> `inc`.
- Dispatch: mode DISPATCH with `dispatch_addr` = 30 -> 30. Then `hold` = 1 for 2 cycles -> stays 30.
- Memory wait: at state 12, mode WAIT.
  - `moc` low for 3 cycles then high -> 12, 12, 12, 13.
  - `moc` low for 16 cycles -> `FAULT_STATE` (43), and `mem_timeout` = 1 until reset.
- Stack: 4 CALLs to 40 from states 2, 41, 41, 41, then a 5th CALL -> `stack_err` = 1 and `stack_depth` = 4. Then 4 RETURNs -> 42, 42, 42, 3. A 5th RETURN -> `FETCH_STATE` (1).
- Async reset mid-WAIT with `wait_cnt` = 9 -> `next_state` = 0 without waiting for a clock edge. A subsequent WAIT needs 16 fresh low cycles to time out.

Source files
------------

// File: rtl/microsequencer.sv
// Next-state generator for the microprogrammed control unit: registered microstate
// with increment/jump/dispatch/branch/wait/call/return. Define MICROSEQ_STACK_EN for the return stack.
module microsequencer #(
  parameter logic [9:0]  FETCH_STATE = 10'd1,
  parameter logic [9:0]  FAULT_STATE = 10'd43,
  parameter logic [7:0]  WAIT_LIMIT  = 8'd16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ctrl_mode,
  input  logic [1:0] cond_sel,
  input  logic       cond_inv,
  input  logic [9:0] branch_target,
  input  logic [9:0] dispatch_addr,
  input  logic       cond_true,
  input  logic       z_flag,
  input  logic       moc,
  input  logic       hold,
  output logic [9:0] next_state,
  output logic [2:0] stack_depth,
  output logic       stack_err,
  output logic       mem_timeout
);

  typedef enum logic [2:0] {
    MODE_INC      = 3'b000,
    MODE_JUMP     = 3'b001,
    MODE_DISPATCH = 3'b010,
    MODE_COND     = 3'b011,
    MODE_WAIT     = 3'b100,
    MODE_CALL     = 3'b101,
    MODE_RETURN   = 3'b110,
    MODE_FETCH    = 3'b111
  } mode_e;

  mode_e      mode;
  logic [9:0] state_q, state_d;
  logic [9:0] inc;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_set;
  logic       cond_raw, cond;

  assign mode       = mode_e'(ctrl_mode);
  assign inc        = state_q + 10'd1;
  assign next_state = state_q;
  assign mem_timeout = timeout_q;

  always_comb begin
    cond_raw = 1'b1;
    case (cond_sel)
      2'b00:   cond_raw = cond_true;
      2'b01:   cond_raw = moc;
      2'b10:   cond_raw = z_flag;
      default: cond_raw = 1'b1;
    endcase
    cond = cond_raw ^ cond_inv;
  end

`ifdef MICROSEQ_STACK_EN
  logic [9:0] stack_q [STACK_DEPTH];
  logic [2:0] depth_q, depth_d;
  logic [9:0] stack_top;
  logic       err_q, err_set;
  logic       push, pop, clear_stack;
  logic       full, empty;

  assign full        = (depth_q == 3'(STACK_DEPTH));
  assign empty       = (depth_q == 3'd0);
  assign stack_depth = depth_q;
  assign stack_err   = err_q;

  // Loop-based read avoids indexing the array with the wider depth counter.
  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == 3'(i + 1)) stack_top = stack_q[i];
    end
  end
`else
  assign stack_depth = '0;
  assign stack_err   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    timeout_set = 1'b0;
`ifdef MICROSEQ_STACK_EN
    push        = 1'b0;
    pop         = 1'b0;
    clear_stack = 1'b0;
    err_set     = 1'b0;
`endif
    case (mode)
      MODE_INC:      state_d = inc;
      MODE_JUMP:     state_d = branch_target;
      MODE_DISPATCH: state_d = dispatch_addr;
      MODE_COND:     state_d = cond ? branch_target : inc;
      MODE_WAIT: begin
        if (moc) begin
          state_d = inc;
        end else if (wait_q == WAIT_LIMIT - 8'd1) begin
          state_d     = FAULT_STATE;
          timeout_set = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
`ifdef MICROSEQ_STACK_EN
      MODE_CALL: begin
        state_d = branch_target;
        if (full) err_set = 1'b1;
        else      push    = 1'b1;
      end
      MODE_RETURN: begin
        if (empty) begin
          state_d = FETCH_STATE;
          err_set = 1'b1;
        end else begin
          state_d = stack_top;
          pop     = 1'b1;
        end
      end
      MODE_FETCH: begin
        state_d     = FETCH_STATE;
        clear_stack = 1'b1;
      end
`else
      MODE_CALL:   state_d = branch_target;
      MODE_RETURN: state_d = FETCH_STATE;
      MODE_FETCH:  state_d = FETCH_STATE;
`endif
    endcase
  end

`ifdef MICROSEQ_STACK_EN
  always_comb begin
    depth_d = depth_q;
    if (clear_stack) depth_d = '0;
    else if (push)   depth_d = depth_q + 3'd1;
    else if (pop)    depth_d = depth_q - 3'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else if (!hold) begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

`ifdef MICROSEQ_STACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (!hold) begin
      depth_q <= depth_d;
      if (err_set) err_q <= 1'b1;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        if (push && depth_q == 3'(i)) stack_q[i] <= inc;
      end
    end
  end
`endif

endmodule
